// File: rtl/rtp_pkg.sv
// Shared RTP definitions: version constant, fixed header size, header layout
// and the fill-FSM state type used by the packetizer.
package rtp_pkg;

  localparam logic [1:0] RTP_VERSION   = 2'd2;
  localparam int         RTP_HDR_BYTES = 12;

  typedef struct packed {
    logic [1:0]  v;
    logic        p;
    logic        x;
    logic [3:0]  cc;
    logic        m;
    logic [6:0]  pt;
    logic [15:0] seq;
    logic [31:0] ts;
    logic [31:0] ssrc;
  } rtp_hdr_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_t;

endpackage

// File: rtl/rtp_frame_buf.sv
// Fill buffer for one packet's worth of frames plus the write index.
// The payload output already includes a frame being written this cycle.
module rtp_frame_buf
  import rtp_pkg::*;
#(
  parameter int FRAME_W = 32,
  parameter int DEPTH   = 237
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr,
  input  logic [FRAME_W-1:0]                 data,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] frame_cnt,
  output logic                               last,
  output logic [FRAME_W*DEPTH-1:0]           payload
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FRAME_W-1:0] mem [DEPTH];

  assign last = (frame_cnt == CNT_W'(DEPTH - 1));

  // Write index: wraps to zero after the last frame of a packet
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (wr) begin
      frame_cnt <= last ? '0 : frame_cnt + CNT_W'(1);
    end
  end

  // Frame storage
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[frame_cnt] <= data;
    end
  end

  // Frame 0 in the MSBs; bypass the incoming frame so a full packet is visible on its last write
  always_comb begin
    payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      payload[(DEPTH-i)*FRAME_W-1 -: FRAME_W] = (wr && (frame_cnt == CNT_W'(i))) ? data : mem[i];
    end
  end

endmodule

// File: rtl/rtp_packetizer.sv
// Packs audio frames into RTP packets (header + big-endian payload) behind a valid/ready output register.
// Optional marker-bit generation is enabled with macro RTP_MARKER_EN.
module rtp_packetizer
  import rtp_pkg::*;
#(
  parameter int          CHANNELS        = 2,
  parameter int          SAMPLE_W        = 16,
  parameter int          SAMPLES_PER_PKT = 237,
  parameter logic [6:0]  PT              = 7'd0,
  parameter logic [31:0] SSRC            = 32'h12345678,
  localparam int         UDP_LENGTH      = RTP_HDR_BYTES + CHANNELS*SAMPLES_PER_PKT*SAMPLE_W/8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*SAMPLE_W-1:0] wav_in_data,
  input  logic                        wav_wren,
  output logic                        udp_send_data_valid,
  input  logic                        udp_send_data_ready,
  output logic [UDP_LENGTH*8-1:0]     udp_send_data,
  output logic [15:0]                 udp_send_data_length,
  output logic [15:0]                 drop_cnt
);

  localparam int FRAME_W   = CHANNELS * SAMPLE_W;
  localparam int PAYLOAD_W = FRAME_W * SAMPLES_PER_PKT;
  localparam int CNT_W     = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;

  fill_state_t            state, state_n;
  logic                   wr, last, xfer, drop, fire, marker;
  logic [CNT_W-1:0]       frame_cnt;
  logic [PAYLOAD_W-1:0]   payload;
  logic [31:0]            frame_ctr, ts_cap;
  logic [15:0]            seq;
  rtp_hdr_t               hdr;

  assign udp_send_data_length = 16'(UDP_LENGTH);
  assign fire = udp_send_data_valid && udp_send_data_ready;
  assign wr   = (state == FILL) && wav_wren;

  rtp_frame_buf #(
    .FRAME_W (FRAME_W),
    .DEPTH   (SAMPLES_PER_PKT)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .data      (wav_in_data),
    .frame_cnt (frame_cnt),
    .last      (last),
    .payload   (payload)
  );

  // Fill FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  // Next state, transfer and drop decisions
  always_comb begin
    state_n = state;
    xfer    = 1'b0;
    drop    = 1'b0;
    case (state)
      FILL: begin
        if (wr && last) begin
          if (!udp_send_data_valid || fire) begin
            xfer = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end else begin
          state_n = FILL;
        end
      end
      HOLD: begin
        drop = wav_wren;
        // The output register drains one cycle after the handshake; the held packet moves in then
        if (!udp_send_data_valid) begin
          xfer    = 1'b1;
          state_n = FILL;
        end else begin
          state_n = HOLD;
        end
      end
      default: state_n = FILL;
    endcase
  end

`ifdef RTP_MARKER_EN
  logic gap, first_pkt, hold_m, m_now;

  assign m_now  = gap | first_pkt;
  assign marker = (state == HOLD) ? hold_m : m_now;

  // Marker is decided when a packet completes; drops while holding mark the following packet
  always_ff @(posedge clk) begin
    if (rst) begin
      gap       <= 1'b0;
      first_pkt <= 1'b1;
      hold_m    <= 1'b0;
    end else if (drop) begin
      gap <= 1'b1;
    end else if (wr && last) begin
      gap       <= 1'b0;
      first_pkt <= 1'b0;
      hold_m    <= m_now;
    end
  end
`else
  assign marker = 1'b0;
`endif

  // Header assembly; timestamp bypasses the capture register on a packet's first frame
  always_comb begin
    hdr.v    = RTP_VERSION;
    hdr.p    = 1'b0;
    hdr.x    = 1'b0;
    hdr.cc   = 4'd0;
    hdr.m    = marker;
    hdr.pt   = PT;
    hdr.seq  = seq;
    hdr.ts   = (wr && (frame_cnt == '0)) ? frame_ctr : ts_cap;
    hdr.ssrc = SSRC;
  end

  // Free-running frame counter, timestamp capture and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ctr <= 32'd0;
      ts_cap    <= 32'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (wav_wren) begin
        frame_ctr <= frame_ctr + 32'd1;
      end
      if (wr && (frame_cnt == '0)) begin
        ts_cap <= frame_ctr;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Output register with valid/ready handshake and sequence numbering
  always_ff @(posedge clk) begin
    if (rst) begin
      udp_send_data_valid <= 1'b0;
      udp_send_data       <= '0;
      seq                 <= 16'd0;
    end else if (xfer) begin
      udp_send_data_valid <= 1'b1;
      udp_send_data       <= {hdr, payload};
      seq                 <= seq + 16'd1;
    end else if (fire) begin
      udp_send_data_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rtp_packetizer.md
RTP_PACKETIZER -- requirements
Module: rtp_packetizer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning audio channels per frame (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning bits per sample (16 or 24).
REQ-003 SHALL have parameter SAMPLES_PER_PKT, default 237, meaning frames per packet.
REQ-004 SHALL have parameter PT, default 7'd0, meaning RTP payload type.
REQ-005 SHALL have parameter SSRC, default 32'h12345678, meaning RTP source identifier.
REQ-006 SHALL have derived localparam UDP_LENGTH = 12 + CHANNELS*SAMPLES_PER_PKT*SAMPLE_W/8, in bytes.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, meaning a synchronous, active-high reset.
REQ-009 SHALL have port wav_in_data, input, CHANNELS*SAMPLE_W bits, meaning one frame; channel 0 is in the MSBs; samples are signed.
REQ-010 SHALL have port wav_wren, input, 1 bit, meaning a frame is present this cycle.
REQ-011 SHALL have port udp_send_data_valid, output, 1 bit, meaning a packet is available.
REQ-012 SHALL have port udp_send_data_ready, input, 1 bit, meaning the consumer accepts the packet.
REQ-013 SHALL have port udp_send_data, output, UDP_LENGTH*8 bits, meaning the packet; byte 0 is in the MSBs.
REQ-014 SHALL have port udp_send_data_length, output, 16 bits, meaning the constant UDP_LENGTH.
REQ-015 SHALL have port drop_cnt, output, 16 bits, meaning dropped frames; saturates at 16'hFFFF.

Function
REQ-016 SHALL lay out each packet as {V=2,P=0,X=0,CC=0, M, PT, seq[15:0], ts[31:0], SSRC, payload}, all fields big-endian.
REQ-017 SHALL place frame 0 of the packet first in the payload, with frames following in arrival order.
REQ-018 SHALL use two storage stages: a fill buffer and an output register.
REQ-019 SHALL have fill FSM states FILL and HOLD.
REQ-020 SHALL, in FILL, write each wav_wren frame at index frame_cnt and increment frame_cnt.
REQ-021 SHALL, on the frame with frame_cnt==SAMPLES_PER_PKT-1, transfer the buffer to the output register if the output register is empty or (valid && ready) in that cycle; otherwise it SHALL enter HOLD.
REQ-022 SHALL, in HOLD, transfer to the output register on the cycle after valid && ready and then return to FILL with frame_cnt=0.
REQ-023 SHALL, in HOLD, drop any wav_wren frame, increment drop_cnt, and set the gap flag.
REQ-024 SHALL assert udp_send_data_valid on the cycle after a transfer.
REQ-025 SHALL hold udp_send_data_valid and udp_send_data stable until the cycle after valid && ready.
REQ-026 SHALL support back-to-back packets with no bubble when ready is held high.
REQ-027 SHALL maintain a free-running 32-bit frame counter that increments on every wav_wren, including dropped frames.
REQ-028 SHALL set ts to the frame-counter value captured at the packet's first frame; ts wraps modulo 2^32.
REQ-029 SHALL increment seq by 1 per transferred packet; seq wraps from 16'hFFFF to 0; the first packet has seq=0.
REQ-030 SHALL accept a wav_wren and a valid && ready in the same cycle with no loss.

Reset
REQ-031 SHALL, on reset, clear udp_send_data_valid, drop_cnt, seq, the frame counter, frame_cnt and the gap flag, and set the FSM to FILL.
REQ-032 SHALL zero udp_send_data under reset.
REQ-033 SHALL discard any partial packet or pending packet when reset is asserted mid-operation.

Configuration
REQ-034 SHALL, with macro RTP_MARKER_EN defined, set M=1 on the first packet after reset and on the first packet completed after any drop (the gap flag), then clear the gap flag.
REQ-035 SHALL, without RTP_MARKER_EN, keep M=0 always and omit the gap-flag logic.

Structure
REQ-036 SHALL place the RTP version constant (2'd2), RTP_HDR_BYTES=12, and a header-field typedef in the shared package rtp_pkg.
REQ-037 SHALL place the fill buffer and frame_cnt in the sub-module rtp_frame_buf, with the FSM, header and output register in the top level.

Verification
REQ-038 SHALL verify that, with CHANNELS=2, SAMPLES_PER_PKT=4 and ready held high, 8 frames of ramp data produce two packets with seq 0,1, ts 0,4, correct byte order and length 28.
REQ-039 SHALL verify that, with ready low through 12 frames, the second packet enters HOLD, drop_cnt=4, and after ready rises the next packet has ts=12.
REQ-040 SHALL verify that, with RTP_MARKER_EN, M=1 on packet 0, M=0 on packet 1, and M=1 on the first packet after a drop; without the macro, M=0 always.
REQ-041 SHALL verify that, with seq preloaded to 16'hFFFF by forcing, the next two packets have seq 16'hFFFF then 16'h0000.
REQ-042 SHALL verify that asserting rst in the middle of frame 2 with a pending output gives valid=0 next cycle and that the following packet has seq=0 and ts=0.
REQ-043 SHALL verify that, when the last frame and valid && ready coincide, the transfer is immediate, valid stays high, and there is no drop.
